mem_stage: RTL and testbench

Fourth stage of the cqu_mips five-stage pipeline, between execute and writeback. Captures the execute stage's registered outputs, issues loads and stores on a request/address-ok/data-ok SRAM-style data bus, aligns and extends load data, and checks address alignment. Stalls execute while a bus transaction is outstanding. Presents the write-back value, destination register and write enable to writeback.

---
 rtl/mem_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: fourth stage of the cqu_mips pipeline, between execute and writeback.
//
// Captures the execute stage's registered outputs whenever the stage is not
// stalled, issues loads/stores on an SRAM-style req/addr_ok/data_ok bus,
// aligns and extends load data, checks address alignment and presents the
// write-back value to writeback.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   flush                     discard the instruction in this stage
//   exe_valid .. pc           execute stage outputs (captured when !mem_stall)
//   data_req .. data_wstrb    bus request side (driven only in REQ)
//   data_addr_ok, data_data_ok, data_rdata   bus response side
//   mem_stall                 hold execute and everything upstream
//   mem_valid, wb_result, wb_reg, wb_reg_write   write-back outputs
//   adel, ades, bad_vaddr     alignment exceptions
//   pc_out                    PC of the last completed instruction
module mem_stage #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        exe_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  write_reg,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        mem_stall,
    output logic        mem_valid,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_reg,
    output logic        wb_reg_write,
    output logic        adel,
    output logic        ades,
    output logic [31:0] bad_vaddr,
    output logic [31:0] pc_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    // Select the addressed byte/half of a load word and extend it.
    function automatic logic [31:0] load_align(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    load_align = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    load_align = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: load_align = word;
        endcase
    endfunction

    logic [1:0]  state;
    logic        vld_p0;
    logic        kill_p0;
    logic [31:0] addr_p0;
    logic [31:0] sdata_p0;
    logic [31:0] pc_p0;
    logic [5:0]  op_p0;
    logic [4:0]  reg_p0;
    logic        reg_write_p0;
    logic        mem_to_reg_p0;
    logic        mem_read_p0;
    logic        mem_write_p0;

    logic [1:0]  size_p0;
    logic        misalign_p0;
    logic        fault_p0;
    logic        go_mem;
    logic        in_req;
    logic        complete;
    logic        discard;
    logic [3:0]  wstrb_c;
    logic [31:0] wdata_c;
    logic        unused_inst;

    assign unused_inst = ^inst[25:0];

    // ---- stage p0: captured execute outputs (data only, no reset needed) ----
    always_ff @(posedge clk) begin
        if (!mem_stall) begin
            addr_p0       <= alu_result;
            sdata_p0      <= store_data;
            pc_p0         <= pc;
            op_p0         <= inst[31:26];
            reg_p0        <= write_reg;
            reg_write_p0  <= reg_write;
            mem_to_reg_p0 <= mem_to_reg;
            mem_read_p0   <= mem_read;
            mem_write_p0  <= mem_write;
        end
    end

    // Access size from opcode low bits: x00 byte, x01 half, x11 word.
    always_comb begin
        case (op_p0[1:0])
            2'b00:   size_p0 = 2'd0;
            2'b01:   size_p0 = 2'd1;
            default: size_p0 = 2'd2;
        endcase
    end

    assign misalign_p0 = ((size_p0 == 2'd1) & addr_p0[0]) |
                         ((size_p0 == 2'd2) & (|addr_p0[1:0]));
    assign fault_p0    = ALIGN_CHECK && vld_p0 && (mem_read_p0 || mem_write_p0) && misalign_p0;
    assign go_mem      = vld_p0 && (mem_read_p0 || mem_write_p0) && !fault_p0;
    assign in_req      = (state == REQ);
    assign complete    = (in_req && data_addr_ok && data_data_ok) ||
                         ((state == WAIT) && data_data_ok);
    assign discard     = kill_p0 || flush;

    assign mem_stall = in_req || ((state == WAIT) && !data_data_ok) ||
                       ((state == IDLE) && go_mem);

    always_comb begin
        wstrb_c = 4'b0000;
        wdata_c = sdata_p0;
        case (size_p0)
            2'd0: begin
                wstrb_c = 4'b0001 << addr_p0[1:0];
                wdata_c = {4{sdata_p0[7:0]}};
            end
            2'd1: begin
                wstrb_c = addr_p0[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{sdata_p0[15:0]}};
            end
            default: wstrb_c = 4'b1111;
        endcase
        if (!mem_write_p0) wstrb_c = 4'b0000;
    end

    // Bus outputs are forced to zero outside REQ so reset and idle look clean.
    assign data_req   = in_req;
    assign data_wr    = in_req & mem_write_p0;
    assign data_size  = in_req ? size_p0 : 2'd0;
    assign data_addr  = in_req ? addr_p0 : 32'h0;
    assign data_wdata = in_req ? wdata_c : 32'h0;
    assign data_wstrb = in_req ? wstrb_c : 4'b0000;

    // ---- stage p1: control state and registered write-back outputs ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            vld_p0       <= 1'b0;
            kill_p0      <= 1'b0;
            mem_valid    <= 1'b0;
            wb_result    <= 32'h0;
            wb_reg       <= 5'd0;
            wb_reg_write <= 1'b0;
            adel         <= 1'b0;
            ades         <= 1'b0;
            bad_vaddr    <= 32'h0;
            pc_out       <= 32'h0;
        end else begin
            mem_valid    <= 1'b0;
            wb_reg_write <= 1'b0;
            adel         <= 1'b0;
            ades         <= 1'b0;

            if (!mem_stall) begin
                vld_p0  <= exe_valid & ~flush;
                kill_p0 <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (vld_p0 && !flush) begin
                        if (go_mem) begin
                            state <= REQ;
                        end else begin
                            mem_valid    <= 1'b1;
                            wb_result    <= addr_p0;
                            wb_reg       <= reg_p0;
                            wb_reg_write <= reg_write_p0 & ~mem_write_p0 & ~fault_p0;
                            adel         <= fault_p0 & mem_read_p0;
                            ades         <= fault_p0 & mem_write_p0;
                            pc_out       <= pc_p0;
                            if (fault_p0) bad_vaddr <= addr_p0;
                        end
                    end else if (go_mem) begin
                        // Flushed while stalled: nothing new is captured, so drop it here.
                        vld_p0 <= 1'b0;
                    end
                end
                REQ: begin
                    if (data_addr_ok) begin
                        if (data_data_ok) begin
                            state  <= IDLE;
                            vld_p0 <= 1'b0;
                        end else begin
                            state <= WAIT;
                            if (flush) kill_p0 <= 1'b1;
                        end
                    end else if (flush) begin
                        state  <= IDLE;
                        vld_p0 <= 1'b0;
                    end
                end
                WAIT: begin
                    if (data_data_ok) state <= IDLE;
                    else if (flush) kill_p0 <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            // An accepted transaction always drains; a flushed one is simply not reported.
            if (complete && !discard) begin
                mem_valid    <= 1'b1;
                wb_result    <= mem_to_reg_p0 ?
                                load_align(data_rdata, addr_p0[1:0], size_p0, op_p0[2]) :
                                addr_p0;
                wb_reg       <= reg_p0;
                wb_reg_write <= reg_write_p0 & ~mem_write_p0;
                pc_out       <= pc_p0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage. Expected write-back records are
// queued when an instruction is driven and checked when mem_valid rises.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        exe_valid = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic [4:0]  write_reg = '0;
    logic        reg_write = 1'b0;
    logic        mem_to_reg = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] inst = '0;
    logic [31:0] pc = '0;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;
    logic        mem_stall, mem_valid, wb_reg_write, adel, ades;
    logic [31:0] wb_result, bad_vaddr, pc_out;
    logic [4:0]  wb_reg;

    always #5 clk = ~clk;

    mem_stage #(.ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .exe_valid(exe_valid),
        .alu_result(alu_result), .store_data(store_data), .write_reg(write_reg),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
        .mem_write(mem_write), .inst(inst), .pc(pc),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_stall(mem_stall), .mem_valid(mem_valid), .wb_result(wb_result),
        .wb_reg(wb_reg), .wb_reg_write(wb_reg_write), .adel(adel), .ades(ades),
        .bad_vaddr(bad_vaddr), .pc_out(pc_out)
    );

    localparam logic [5:0] OP_ALU = 6'h00;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rg;
        logic        we;
        logic        adel;
        logic        ades;
        logic [31:0] bva;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    int          vec = 0;
    int          bad = 0;
    logic [31:0] cur_pc = 32'h0040_0000;

    // Scoreboard: every completion must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rstn && mem_valid) begin
            vec++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected: mem_valid=1 wb_result=%h, required no completion", wb_result);
            end else begin
                e_mon = sb.pop_front();
                if ({wb_reg_write, adel, ades} !== {e_mon.we, e_mon.adel, e_mon.ades}) begin
                    bad++;
                    $display("FAIL wb_flags: we/adel/ades=%b%b%b required %b%b%b",
                             wb_reg_write, adel, ades, e_mon.we, e_mon.adel, e_mon.ades);
                end
                vec++;
                if (pc_out !== e_mon.pc) begin
                    bad++;
                    $display("FAIL wb_pc: pc_out=%h required %h", pc_out, e_mon.pc);
                end
                if (e_mon.we) begin
                    vec++;
                    if (wb_result !== e_mon.res || wb_reg !== e_mon.rg) begin
                        bad++;
                        $display("FAIL wb_value: result=%h reg=%0d required %h reg %0d",
                                 wb_result, wb_reg, e_mon.res, e_mon.rg);
                    end
                end
                if (e_mon.adel || e_mon.ades) begin
                    vec++;
                    if (bad_vaddr !== e_mon.bva) begin
                        bad++;
                        $display("FAIL wb_badvaddr: bad_vaddr=%h required %h", bad_vaddr, e_mon.bva);
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] res, input logic [4:0] rg, input logic we,
                            input logic ael, input logic aes, input logic [31:0] bva);
        exp_t e;
        e.res = res; e.rg = rg; e.we = we; e.adel = ael; e.ades = aes; e.bva = bva; e.pc = cur_pc;
        sb.push_back(e);
    endtask

    // Present one instruction for exactly one capture edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] wr, input logic rw, input logic m2r,
                         input logic mr, input logic mw);
        inst = {op, 26'h0000021}; alu_result = alu; store_data = sd; write_reg = wr;
        reg_write = rw; mem_to_reg = m2r; mem_read = mr; mem_write = mw; pc = cur_pc;
        exe_valid = 1'b1;
        @(posedge clk); #1;
        exe_valid = 1'b0;
        cur_pc = cur_pc + 32'd4;
    endtask

    // Bus slave: waits for a request, accepts it at once and returns data after do_wait cycles.
    task automatic run_bus(input int do_wait, input logic [31:0] rd, output bit got,
                           output logic [3:0] strb, output logic [31:0] wd, output logic wr);
        got = 1'b0; strb = '0; wd = '0; wr = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = data_req;
        end
        if (!got) return;
        strb = data_wstrb; wd = data_wdata; wr = data_wr;
        data_addr_ok = 1'b1; data_rdata = rd;
        if (do_wait == 0) data_data_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        if (do_wait > 0) begin
            repeat (do_wait - 1) @(posedge clk);
            @(negedge clk);
            data_data_ok = 1'b1;
            @(posedge clk); #1;
            data_data_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec++;
        if ({mem_valid, data_req, mem_stall, wb_reg_write, adel, ades, data_wr} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {mem_valid, data_req, mem_stall, wb_reg_write, adel, ades, data_wr});
        end
        vec++;
        if ({wb_result, bad_vaddr, pc_out, data_addr, data_wdata, wb_reg, data_wstrb, data_size} !== '0) begin
            bad++;
            $display("FAIL reset_data: wb_result=%h bad_vaddr=%h pc_out=%h addr=%h required all zero",
                     wb_result, bad_vaddr, pc_out, data_addr);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu;
        push_exp(32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0);
        issue(OP_ALU, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        vec++;
        if ({mem_valid, data_req, mem_stall} !== 3'b000) begin
            bad++;
            $display("FAIL alu_early: valid/req/stall=%b required 000", {mem_valid, data_req, mem_stall});
        end
        @(negedge clk);
        vec++;
        if ({mem_valid, data_req} !== 2'b10) begin
            bad++;
            $display("FAIL alu_valid: valid/req=%b required 10", {mem_valid, data_req});
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] seen;
        for (int i = 1; i <= 3; i++) begin
            push_exp(32'h1000_0000 + i, 5'(i), 1'b1, 1'b0, 1'b0, 32'h0);
            issue(OP_ALU, 32'h1000_0000 + i, 32'h0, 5'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen[2 - i] = mem_valid;
        end
        vec++;
        if (seen !== 3'b110) begin
            bad++;
            $display("FAIL b2b_valid: mem_valid pattern=%b required 110", seen);
        end
    endtask

    task automatic test_lw_wait;
        bit hold_ok;
        push_exp(32'hDEAD_BEEF, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0);
        issue(OP_LW, 32'h0000_1000, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        vec++;
        if ({data_req, mem_stall} !== 2'b01) begin
            bad++;
            $display("FAIL lw_capture: req/stall=%b required 01", {data_req, mem_stall});
        end
        hold_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!(data_req === 1'b1 && data_addr === 32'h1000 && data_wr === 1'b0 &&
                  data_size === 2'd2 && data_wstrb === 4'b0 && mem_stall === 1'b1)) hold_ok = 1'b0;
            if (i == 2) data_addr_ok = 1'b1;
        end
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        vec++;
        if (!hold_ok) begin
            bad++;
            $display("FAIL lw_req_hold: req=%b addr=%h size=%0d stall=%b required stable 1/00001000/2/1",
                     data_req, data_addr, data_size, mem_stall);
        end
        @(negedge clk);
        vec++;
        if ({data_req, mem_stall, mem_valid} !== 3'b010) begin
            bad++;
            $display("FAIL lw_wait: req/stall/valid=%b required 010", {data_req, mem_stall, mem_valid});
        end
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        #1;
        vec++;
        if (mem_stall !== 1'b0) begin
            bad++;
            $display("FAIL lw_dataok_stall: mem_stall=%b required 0", mem_stall);
        end
        @(posedge clk); #1;
        data_data_ok = 1'b0; data_rdata = '0;
        @(negedge clk);
        vec++;
        if (mem_valid !== 1'b1) begin
            bad++;
            $display("FAIL lw_done: mem_valid=%b required 1", mem_valid);
        end
    endtask

    task automatic test_subword_loads;
        logic [5:0]  op  [8];
        logic [31:0] ad  [8];
        logic [31:0] ex  [8];
        bit          got;
        logic [3:0]  s;
        logic [31:0] w;
        logic        wr;
        op = '{OP_LB, OP_LBU, OP_LB, OP_LH, OP_LHU, OP_LBU, OP_LH, OP_LW};
        ad = '{32'h2003, 32'h2003, 32'h2000, 32'h2002, 32'h2002, 32'h2001, 32'h2000, 32'h2000};
        ex = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FF80, 32'hFFFF_80FF,
               32'h0000_80FF, 32'h0000_007F, 32'h0000_7F80, 32'h80FF_7F80};
        for (int i = 0; i < 8; i++) begin
            push_exp(ex[i], 5'd10 + 5'(i), 1'b1, 1'b0, 1'b0, 32'h0);
            issue(op[i], ad[i], 32'h0, 5'd10 + 5'(i), 1'b1, 1'b1, 1'b1, 1'b0);
            run_bus(i % 2, 32'h80FF_7F80, got, s, w, wr);
            vec++;
            if (!got || wr !== 1'b0 || s !== 4'b0) begin
                bad++;
                $display("FAIL ld_req[%0d]: got=%b wr=%b wstrb=%b required 1/0/0000", i, got, wr, s);
            end
            @(negedge clk);
            vec++;
            if (mem_valid !== 1'b1) begin
                bad++;
                $display("FAIL ld_done[%0d]: mem_valid=%b required 1", i, mem_valid);
            end
        end
    endtask

    task automatic test_stores;
        logic [5:0]  op  [4];
        logic [31:0] ad  [4];
        logic [3:0]  es  [4];
        logic [31:0] ew  [4];
        bit          got;
        logic [3:0]  s;
        logic [31:0] w;
        logic        wr;
        op = '{OP_SB, OP_SH, OP_SW, OP_SB};
        ad = '{32'h3003, 32'h3002, 32'h3000, 32'h3000};
        es = '{4'b1000, 4'b1100, 4'b1111, 4'b0001};
        ew = '{32'hABAB_ABAB, 32'h56AB_56AB, 32'h1234_56AB, 32'hABAB_ABAB};
        for (int i = 0; i < 4; i++) begin
            push_exp(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
            issue(op[i], ad[i], 32'h1234_56AB, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            run_bus(i % 2, 32'h0, got, s, w, wr);
            vec++;
            if (!got || wr !== 1'b1 || s !== es[i] || w !== ew[i]) begin
                bad++;
                $display("FAIL st_bus[%0d]: got=%b wr=%b wstrb=%b wdata=%h required 1/1/%b/%h",
                         i, got, wr, s, w, es[i], ew[i]);
            end
            @(negedge clk);
            vec++;
            if ({mem_valid, wb_reg_write} !== 2'b10) begin
                bad++;
                $display("FAIL st_done[%0d]: valid/we=%b required 10", i, {mem_valid, wb_reg_write});
            end
        end
    endtask

    task automatic test_misaligned;
        logic [5:0]  op [4];
        logic [31:0] ad [4];
        logic        saw;
        op = '{OP_LW, OP_SH, OP_LHU, OP_SW};
        ad = '{32'h1002, 32'h1001, 32'h1003, 32'h1002};
        for (int i = 0; i < 4; i++) begin
            logic is_st;
            is_st = (op[i] == OP_SH) || (op[i] == OP_SW);
            push_exp(32'h0, 5'd3, 1'b0, !is_st, is_st, ad[i]);
            issue(op[i], ad[i], 32'h5555_AAAA, 5'd3, !is_st, !is_st, !is_st, is_st);
            @(negedge clk);
            saw = data_req | mem_stall;
            @(negedge clk);
            saw = saw | data_req;
            vec++;
            if (saw !== 1'b0 || mem_valid !== 1'b1) begin
                bad++;
                $display("FAIL misalign[%0d]: req_or_stall=%b mem_valid=%b required 0/1", i, saw, mem_valid);
            end
        end
    endtask

    task automatic test_flush;
        bit stall_ok;
        // flush while the request is still waiting for addr_ok
        issue(OP_LW, 32'h0000_1000, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        vec++;
        if ({data_req, mem_stall, mem_valid} !== 3'b000) begin
            bad++;
            $display("FAIL flush_req: req/stall/valid=%b required 000", {data_req, mem_stall, mem_valid});
        end
        // flush after acceptance: transaction drains, result discarded
        issue(OP_LW, 32'h0000_1004, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        stall_ok = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (mem_stall !== 1'b1 || mem_valid !== 1'b0) stall_ok = 1'b0;
        end
        vec++;
        if (!stall_ok) begin
            bad++;
            $display("FAIL flush_wait_stall: stall=%b valid=%b required 1/0", mem_stall, mem_valid);
        end
        data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        @(negedge clk);
        vec++;
        if ({mem_valid, mem_stall, wb_reg_write} !== 3'b000) begin
            bad++;
            $display("FAIL flush_wait_discard: valid/stall/we=%b required 000", {mem_valid, mem_stall, wb_reg_write});
        end
        // stage still works afterwards
        push_exp(32'h0000_0077, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0);
        issue(OP_ALU, 32'h0000_0077, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        vec++;
        if (mem_valid !== 1'b1) begin
            bad++;
            $display("FAIL flush_recover: mem_valid=%b required 1", mem_valid);
        end
    endtask

    task automatic test_reset_midreq;
        issue(OP_LW, 32'h0000_1008, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        vec++;
        if (data_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_req: data_req=%b required 1", data_req);
        end
        rstn = 1'b0;
        #1;
        vec++;
        if ({data_req, mem_stall, mem_valid, data_wr, data_size, data_wstrb, data_addr, data_wdata,
             wb_result, wb_reg, wb_reg_write, adel, ades, bad_vaddr, pc_out} !== '0) begin
            bad++;
            $display("FAIL rst_midreq: req=%b stall=%b addr=%h wb_result=%h pc_out=%h bad_vaddr=%h required all zero",
                     data_req, mem_stall, data_addr, wb_result, pc_out, bad_vaddr);
        end
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        vec++;
        if ({data_req, mem_stall, mem_valid} !== 3'b000) begin
            bad++;
            $display("FAIL rst_after: req/stall/valid=%b required 000", {data_req, mem_stall, mem_valid});
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_lw_wait();
        test_subword_loads();
        test_stores();
        test_misaligned();
        test_flush();
        test_reset_midreq();
        repeat (2) @(negedge clk);
        vec++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d completions outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
